// File: rtl/cby_ccff_loader_if.sv
// Configuration word handshake between a bitstream source and the CBY chain loader.
// The source drives data/valid; the loader answers with ready.
interface cby_ccff_loader_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;

  modport master (
    output cfg_data,
    output cfg_valid,
    input  cfg_ready
  );

  modport slave (
    input  cfg_data,
    input  cfg_valid,
    output cfg_ready
  );
endinterface

// File: rtl/cby_ccff_loader.sv
// Serialises configuration words MSB-first onto a CBY tile's ccff chain, gating prog_clk
// per shifted bit, and keeps CRC-16 signatures of the head and tail streams for loopback.
module cby_ccff_loader #(
  parameter int CHAIN_LEN = 16,
  parameter int WORD_W    = 8
) (
  input  logic                 prog_clk,
  input  logic                 prog_reset,
  input  logic                 start,
  input  logic                 abort,
  cby_ccff_loader_if.slave     cfg,
  output logic                 ccff_head,
  input  logic                 ccff_tail,
  output logic                 chain_clk_en,
  output logic                 busy,
  output logic                 done,
  output logic                 match,
  output logic [15:0]          crc_in,
  output logic [15:0]          crc_out
);

  localparam int BW = $clog2(WORD_W + 1);
  localparam int RW = $clog2(CHAIN_LEN + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_WORD,
    SHIFT,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] shiftReg_q, shiftReg_d;
  logic [BW-1:0]     bitsLeft_q, bitsLeft_d;
  logic [RW-1:0]     remaining_q, remaining_d;
  logic [15:0]       crcIn_q, crcIn_d;
  logic [15:0]       crcOut_q, crcOut_d;
  logic [15:0]       prevCrc_q;
  logic              prevValid_q;
  logic              match_q;
  logic              busy_q;
  logic              done_q;
  logic              ready_q;
  logic              clkEn_q;
  logic              head_q;
  logic              aborting;

  // CCITT 0x1021, MSB-first, one bit per call.
  function automatic logic [15:0] crcStep(input logic [15:0] crc, input logic dataBit);
    logic fb;
    fb = crc[15] ^ dataBit;
    return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  assign aborting = (state_q != IDLE) && abort;

  always_comb begin
    state_d     = state_q;
    shiftReg_d  = shiftReg_q;
    bitsLeft_d  = bitsLeft_q;
    remaining_d = remaining_q;
    crcIn_d     = crcIn_q;
    crcOut_d    = crcOut_q;
    if (aborting) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_d     = WAIT_WORD;
            crcIn_d     = 16'hFFFF;
            crcOut_d    = 16'hFFFF;
            remaining_d = RW'(CHAIN_LEN);
          end
        end
        WAIT_WORD: begin
          if (cfg.cfg_valid) begin
            shiftReg_d = cfg.cfg_data;
            bitsLeft_d = (int'(remaining_q) >= WORD_W) ? BW'(WORD_W) : BW'(remaining_q);
            state_d    = SHIFT;
          end
        end
        SHIFT: begin
          // The tail bit seen this cycle is the one leaving the chain on this edge.
          crcIn_d     = crcStep(crcIn_q, shiftReg_q[WORD_W-1]);
          crcOut_d    = crcStep(crcOut_q, ccff_tail);
          shiftReg_d  = shiftReg_q << 1;
          bitsLeft_d  = bitsLeft_q - BW'(1);
          remaining_d = remaining_q - RW'(1);
          if (bitsLeft_q == BW'(1)) begin
            state_d = (remaining_q == RW'(1)) ? DONE : WAIT_WORD;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge prog_clk or negedge prog_reset) begin
    if (!prog_reset) begin
      state_q     <= IDLE;
      shiftReg_q  <= '0;
      bitsLeft_q  <= '0;
      remaining_q <= '0;
      crcIn_q     <= 16'hFFFF;
      crcOut_q    <= 16'hFFFF;
      prevCrc_q   <= 16'hFFFF;
      prevValid_q <= 1'b0;
      match_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b0;
      clkEn_q     <= 1'b0;
      head_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shiftReg_q  <= shiftReg_d;
      bitsLeft_q  <= bitsLeft_d;
      remaining_q <= remaining_d;
      crcIn_q     <= crcIn_d;
      crcOut_q    <= crcOut_d;
      busy_q      <= (state_d != IDLE);
      ready_q     <= (state_d == WAIT_WORD);
      clkEn_q     <= (state_d == SHIFT);
      done_q      <= (state_d == DONE);
      head_q      <= (state_d == SHIFT) & shiftReg_d[WORD_W-1];
      if (aborting) begin
        prevValid_q <= 1'b0;
      end else if (state_q == DONE) begin
        match_q     <= prevValid_q && (crcOut_q == prevCrc_q);
        prevCrc_q   <= crcIn_q;
        prevValid_q <= 1'b1;
      end
    end
  end

  assign cfg.cfg_ready = ready_q;
  assign ccff_head     = head_q;
  assign chain_clk_en  = clkEn_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign match         = match_q;
  assign crc_in        = crcIn_q;
  assign crc_out       = crcOut_q;

endmodule

// File: tb/tb_cby_ccff_loader.sv
// Directed bench for cby_ccff_loader: a 16-flop and a 12-flop behavioural chain,
// each driven by its own loader instance.
module tb_cby_ccff_loader;

  logic        prog_clk = 1'b0;
  logic        prog_reset;
  logic        start, startP, abort;
  logic [7:0]  cfgData;
  logic        cfgValid;
  logic        forceTailZero;
  bit          usePart;

  logic        head, tail, en, busy, done, match;
  logic [15:0] crcIn, crcOut;
  logic        headP, tailP, enP, busyP, doneP, matchP;
  logic [15:0] crcInP, crcOutP;

  logic [15:0] chain  = 16'h0000;
  logic [11:0] chainP = 12'h000;

  logic        obsEn, obsHead, obsBusy, obsDone, obsReady;

  int          total = 0;
  int          bad   = 0;
  int          doneCycle;
  bit          doneSeen;
  bit          timedOut;
  logic [63:0] enMask;
  logic [15:0] headBits;
  logic        busyAfterAbort;

  always #5 prog_clk = ~prog_clk;

  cby_ccff_loader_if #(.WORD_W(8)) cfgIf ();
  cby_ccff_loader_if #(.WORD_W(8)) cfgIfP ();

  assign cfgIf.cfg_data   = cfgData;
  assign cfgIf.cfg_valid  = cfgValid;
  assign cfgIfP.cfg_data  = cfgData;
  assign cfgIfP.cfg_valid = cfgValid;

  cby_ccff_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut (
    .prog_clk     (prog_clk),
    .prog_reset   (prog_reset),
    .start        (start),
    .abort        (abort),
    .cfg          (cfgIf),
    .ccff_head    (head),
    .ccff_tail    (tail),
    .chain_clk_en (en),
    .busy         (busy),
    .done         (done),
    .match        (match),
    .crc_in       (crcIn),
    .crc_out      (crcOut)
  );

  cby_ccff_loader #(.CHAIN_LEN(12), .WORD_W(8)) dutP (
    .prog_clk     (prog_clk),
    .prog_reset   (prog_reset),
    .start        (startP),
    .abort        (abort),
    .cfg          (cfgIfP),
    .ccff_head    (headP),
    .ccff_tail    (tailP),
    .chain_clk_en (enP),
    .busy         (busyP),
    .done         (doneP),
    .match        (matchP),
    .crc_in       (crcInP),
    .crc_out      (crcOutP)
  );

  // Behavioural chains: shift only on gated edges, tail is the last flop.
  always @(posedge prog_clk) begin
    if (en)  chain  <= {chain[14:0], head};
    if (enP) chainP <= {chainP[10:0], headP};
  end

  assign tail  = forceTailZero ? 1'b0 : chain[15];
  assign tailP = chainP[11];

  assign obsEn    = usePart ? enP    : en;
  assign obsHead  = usePart ? headP  : head;
  assign obsBusy  = usePart ? busyP  : busy;
  assign obsDone  = usePart ? doneP  : done;
  assign obsReady = usePart ? cfgIfP.cfg_ready : cfgIf.cfg_ready;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected)
      else begin
        bad++;
        $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  // One pass: T0 is the start cycle, outputs sampled on the falling edge of each cycle.
  task automatic applyStimulus(input logic [7:0] w0, input logic [7:0] w1,
                               input int stall, input int abortAt);
    int t, words, waitSeen, enCnt, abortCycle;
    doneCycle      = 0;
    doneSeen       = 1'b0;
    timedOut       = 1'b1;
    enMask         = '0;
    headBits       = '0;
    busyAfterAbort = 1'b1;
    words          = 0;
    waitSeen       = 0;
    enCnt          = 0;
    abortCycle     = -1;
    @(negedge prog_clk);
    cfgData  = w0;
    cfgValid = 1'b1;
    if (usePart) startP = 1'b1;
    else         start  = 1'b1;
    for (t = 1; t < 60; t++) begin
      @(negedge prog_clk);
      start  = 1'b0;
      startP = 1'b0;
      abort  = 1'b0;
      if (obsEn) begin
        enMask[t] = 1'b1;
        headBits  = {headBits[14:0], obsHead};
        enCnt++;
        if (enCnt == abortAt) begin
          abort      = 1'b1;
          abortCycle = t;
        end
      end
      if (abortCycle >= 0 && t == abortCycle + 1) busyAfterAbort = obsBusy;
      if (obsDone) begin
        doneCycle = t;
        doneSeen  = 1'b1;
        timedOut  = 1'b0;
        break;
      end
      if (abortCycle >= 0 && t >= abortCycle + 4) begin
        timedOut = 1'b0;
        break;
      end
      if (obsReady) begin
        if (words == 1 && waitSeen < stall) begin
          cfgValid = 1'b0;
          waitSeen++;
        end else begin
          cfgValid = 1'b1;
          cfgData  = (words == 0) ? w0 : w1;
          words++;
        end
      end
    end
    cfgValid = 1'b0;
    abort    = 1'b0;
    @(negedge prog_clk);
    checkOutput("passTerminates", 64'(timedOut), 64'd0);
  endtask

  initial begin
    prog_reset    = 1'b0;
    start         = 1'b0;
    startP        = 1'b0;
    abort         = 1'b0;
    cfgData       = 8'h00;
    cfgValid      = 1'b0;
    forceTailZero = 1'b0;
    usePart       = 1'b0;
    repeat (3) @(negedge prog_clk);
    checkOutput("rstReady",  64'(cfgIf.cfg_ready), 64'd0);
    checkOutput("rstHead",   64'(head), 64'd0);
    checkOutput("rstEn",     64'(en), 64'd0);
    checkOutput("rstBusy",   64'(busy), 64'd0);
    checkOutput("rstDone",   64'(done), 64'd0);
    checkOutput("rstMatch",  64'(match), 64'd0);
    checkOutput("rstCrcIn",  64'(crcIn), 64'hFFFF);
    checkOutput("rstCrcOut", 64'(crcOut), 64'hFFFF);
    prog_reset = 1'b1;
    repeat (2) @(negedge prog_clk);

    // Default load 0xA5, 0x3C.
    applyStimulus(8'hA5, 8'h3C, 0, 0);
    checkOutput("aDoneCycle", 64'(doneCycle), 64'd19);
    checkOutput("aEnMask",    enMask, 64'h7FBFC);
    checkOutput("aHeadBits",  64'(headBits), 64'hA53C);
    checkOutput("aChain",     64'(chain), 64'hA53C);
    checkOutput("aCrcIn",     64'(crcIn), 64'h085B);
    checkOutput("aMatch",     64'(match), 64'd0);
    checkOutput("aBusyIdle",  64'(busy), 64'd0);

    // Loopback: tail returns 0xA53C.
    applyStimulus(8'h12, 8'h34, 0, 0);
    checkOutput("bMatch",  64'(match), 64'd1);
    checkOutput("bCrcOut", 64'(crcOut), 64'h085B);
    checkOutput("bChain",  64'(chain), 64'h1234);

    // Asynchronous reset on the third shift cycle.
    @(negedge prog_clk);
    cfgData  = 8'h56;
    cfgValid = 1'b1;
    start    = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    repeat (3) @(negedge prog_clk);
    checkOutput("midShiftEn", 64'(en), 64'd1);
    #2 prog_reset = 1'b0;
    #1;
    checkOutput("arstEn",     64'(en), 64'd0);
    checkOutput("arstHead",   64'(head), 64'd0);
    checkOutput("arstBusy",   64'(busy), 64'd0);
    checkOutput("arstReady",  64'(cfgIf.cfg_ready), 64'd0);
    checkOutput("arstMatch",  64'(match), 64'd0);
    checkOutput("arstCrcIn",  64'(crcIn), 64'hFFFF);
    checkOutput("arstCrcOut", 64'(crcOut), 64'hFFFF);
    @(negedge prog_clk);
    cfgValid   = 1'b0;
    prog_reset = 1'b1;
    @(negedge prog_clk);

    applyStimulus(8'hA5, 8'h3C, 0, 0);
    checkOutput("postRstMatch", 64'(match), 64'd0);
    checkOutput("postRstCrcIn", 64'(crcIn), 64'h085B);

    // Tail stuck low breaks the loopback.
    forceTailZero = 1'b1;
    applyStimulus(8'h12, 8'h34, 0, 0);
    forceTailZero = 1'b0;
    checkOutput("tailZeroMatch", 64'(match), 64'd0);

    // Five-cycle stall before the second word; tail returns 0x1234.
    applyStimulus(8'h56, 8'h78, 5, 0);
    checkOutput("stallDoneCycle", 64'(doneCycle), 64'd24);
    checkOutput("stallEnMask",    enMask, 64'hFF03FC);
    checkOutput("stallMatch",     64'(match), 64'd1);
    checkOutput("stallChain",     64'(chain), 64'h5678);

    // Abort on the third shift cycle.
    applyStimulus(8'hA5, 8'h3C, 0, 3);
    checkOutput("abortEnMask",  enMask, 64'h1C);
    checkOutput("abortNoDone",  64'(doneSeen), 64'd0);
    checkOutput("abortIdle",    64'(busyAfterAbort), 64'd0);
    checkOutput("abortMatchKept", 64'(match), 64'd1);

    applyStimulus(8'h12, 8'h34, 0, 0);
    checkOutput("postAbortMatch", 64'(match), 64'd0);
    checkOutput("postAbortDone",  64'(doneCycle), 64'd19);

    // Partial last word on the 12-flop chain.
    usePart = 1'b1;
    applyStimulus(8'hFF, 8'hA0, 0, 0);
    checkOutput("partDoneCycle", 64'(doneCycle), 64'd15);
    checkOutput("partEnMask",    enMask, 64'h7BFC);
    checkOutput("partHeadBits",  64'(headBits[11:0]), 64'hFFA);
    checkOutput("partChain",     64'(chainP), 64'hFFA);
    checkOutput("partBusyIdle",  64'(busyP), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cby_ccff_loader.md
# cby_ccff_loader

Configuration-chain loader for the connection-block routing tiles, including the single-column blocks with four 12:1 outpad muxes. The block accepts a configuration bitstream as words over a valid/ready handshake and serialises it MSB-first onto a tile's `ccff_head`. It issues one enable per shift to the clock gate feeding that tile's `prog_clk`. It runs CRC-16 signatures over the bits shifted in and over the bits returned on `ccff_tail`, which gives a loopback check of the chain.

## Interface

Parameters:
- `CHAIN_LEN`, default 16: number of configuration flops in the chain. Default is 4 muxes × 4 SRAM bits. Minimum 1.
- `WORD_W`, default 8: configuration word width. Minimum 1.

Ports:
- `prog_clk`, input, 1: block clock. This is the ungated programming clock.
- `prog_reset`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: begin a load pass. Sampled only in IDLE.
- `abort`, input, 1: synchronous cancel of the current pass.
- `cfg_data`, input, WORD_W: configuration word. MSB is shifted first.
- `cfg_valid`, input, 1: `cfg_data` is valid.
- `cfg_ready`, output, 1: block accepts a word this cycle.
- `ccff_head`, output, 1: serial data into the chain.
- `ccff_tail`, input, 1: serial data out of the chain.
- `chain_clk_en`, output, 1: enable to the external clock-gate cell. The chain shifts on each `prog_clk` edge where this is 1.
- `busy`, output, 1: a pass is in progress.
- `done`, output, 1: one-cycle pulse when a pass completes.
- `match`, output, 1: the last completed pass's `ccff_tail` CRC equals the previous pass's head CRC.
- `crc_in`, output, 16: running CRC of bits driven on `ccff_head`.
- `crc_out`, output, 16: running CRC of bits sampled on `ccff_tail`.

## Operation

- State machine: IDLE → WAIT_WORD → SHIFT → (WAIT_WORD | DONE) → IDLE.
- **IDLE**
  - `busy`=0.
  - When `start`=1: go to WAIT_WORD, set `crc_in` and `crc_out` to 0xFFFF, set `remaining`=CHAIN_LEN.
- **WAIT_WORD**
  - `cfg_ready`=1 and `busy`=1.
  - On `cfg_valid`&`cfg_ready`: latch `cfg_data` into the shift register, set `bits`=min(WORD_W, remaining), go to SHIFT.
  - If `cfg_valid`=0, hold indefinitely with `chain_clk_en`=0, so the chain holds its contents.
- **SHIFT**, once per cycle:
  - `ccff_head` = shift-register MSB; `chain_clk_en`=1.
  - Update `crc_in` with the head bit. Sample `ccff_tail` in the same cycle (this is the bit leaving on this edge) and update `crc_out` with it.
  - Shift the register left; decrement `bits` and `remaining`.
  - When `bits` reaches 0: go to DONE if `remaining`=0, else WAIT_WORD.
- **Partial last word:** in the last word only the top `remaining` MSBs are shifted. The lower bits are discarded.
- **DONE**, one cycle, then IDLE:
  - `done`=1.
  - `match` = `prev_valid` && (`crc_out` == `prev_crc`).
  - Then `prev_crc` ← `crc_in` and `prev_valid` ← 1.
- **CRC:** CCITT polynomial 0x1021, MSB-first. Per bit b: `fb` = `crc[15]`^b; `crc` = {`crc[14:0]`,0} ^ (`fb` ? 0x1021 : 0).
- `crc_in`/`crc_out` hold their final values after DONE until the next `start`.
- **abort** in any non-IDLE state:
  - Go to IDLE next cycle, with `chain_clk_en`=0 that cycle.
  - No `done` pulse; `prev_valid` ← 0.
  - `match` and the CRCs are unchanged.
- `start` while busy: ignored.
- `abort` and `start` together in IDLE: `abort` wins and the pass does not start.
- `ccff_head` = 0 whenever not in SHIFT.

## Timing

- Reset values:
  - State IDLE.
  - `cfg_ready`, `ccff_head`, `chain_clk_en`, `busy`, `done`, `match` = 0.
  - `crc_in` = `crc_out` = 0xFFFF.
  - `prev_valid` = 0, `prev_crc` = 0xFFFF.
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs, except that `cfg_ready` is a pure function of state.
- Latency with `cfg_valid` held high and T0 as the `start` cycle:
  - One handshake cycle per word plus one shift cycle per bit.
  - `done` is asserted at T0 + 1 + ceil(CHAIN_LEN/WORD_W) + CHAIN_LEN.
  - With defaults (CHAIN_LEN=16, WORD_W=8) that is T19.
- Exactly CHAIN_LEN `chain_clk_en` cycles occur per completed pass.
- Asynchronous reset mid-pass: immediate IDLE and all reset values above. Chain contents are the chain's own responsibility.

## Test plan

- **Reset:** assert `prog_reset`=0 mid-SHIFT → all outputs at their reset values immediately. After release, a new pass gives `match`=0 (`prev_valid` cleared).
- **Default load:** load 0xA5 then 0x3C into a 16-bit behavioural chain model, `cfg_valid` high.
  - `ccff_head` sequence is 1010_0101_0011_1100 on the 16 enabled cycles.
  - `done` at T19; model holds the bitstream.
  - `crc_in` equals the reference CRC-16 of 0xA53C.
- **Loopback:** run a second pass of 0x12, 0x34 → `match`=1, and `crc_out` equals the first pass's `crc_in`. Repeat with the model's tail forced to 0 → `match`=0.
- **Stall:** drop `cfg_valid` for 5 cycles before the second word → `chain_clk_en`=0 throughout the stall and `done` at T24.
- **Abort:** assert `abort` on the 3rd SHIFT cycle → IDLE the next cycle, no `done`, exactly 3 enables issued. The next full pass gives `match`=0.
- **Partial word:** with CHAIN_LEN=12, WORD_W=8, load 0xFF then 0xA0 → 12 enables, last four head bits 1010, `done` at T15.
